// File: rtl/zrb_uart_tx_arbiter.sv
// Round-robin arbiter that shares one zrb_uart_tx between NUM_REQ byte-stream requesters.
// The winner keeps the transmitter for one packet: until its last byte or BURST_MAX bytes.
module zrb_uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 uart_clk_en,
  input  logic                 uart_busy,
  output logic                 uart_write,
  output logic [7:0]           uart_data,
  output logic                 active
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StRelease} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, pick_oh;
  logic [IdxW-1:0]     owner_q, owner_d, rr_q, rr_d, pick;
  logic [CntW-1:0]     count_q, count_d, count_inc;
  logic                last_q, last_d, write_q, write_d;
  logic [7:0]          data_q, data_d, sel_data;
  logic                sel_req, sel_last, found, accept;

  // Same condition under which uart_tx loads the byte.
  assign accept    = write_q & uart_clk_en & ~uart_busy;
  assign count_inc = count_q + CntW'(1);

  // First requester above the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = rr_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(rr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    pick_oh  = '0;
    sel_data = 8'h00;
    sel_req  = 1'b0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (pick == IdxW'(i));
      if (owner_q == IdxW'(i)) begin
        sel_data = data_in[8*i +: 8];
        sel_req  = req[i];
        sel_last = last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    count_d = count_q;
    last_d  = last_q;
    write_d = write_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick_oh;
          owner_d = pick;
          count_d = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (sel_req) begin
          data_d  = sel_data;
          last_d  = sel_last;
          write_d = 1'b1;
          state_d = StSend;
        end else begin
          state_d = StRelease;
        end
      end
      StSend: begin
        if (accept) begin
          write_d = 1'b0;
          count_d = count_inc;
          state_d = (last_q || count_inc == CntW'(BURST_MAX)) ? StRelease : StLoad;
        end
      end
      StRelease: begin
        grant_d = '0;
        rr_d    = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= IdxW'(NUM_REQ - 1);
      count_q <= '0;
      last_q  <= 1'b0;
      write_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      last_q  <= last_d;
      write_q <= write_d;
      data_q  <= data_d;
    end
  end

  assign ack        = (accept && state_q == StSend) ? grant_q : '0;
  assign grant      = grant_q;
  assign uart_write = write_q;
  assign uart_data  = data_q;
  assign active     = (state_q != StIdle);

endmodule

// File: tb/tb_zrb_uart_tx_arbiter.sv
// Scoreboard bench for zrb_uart_tx_arbiter: queue-backed requesters, a busy/tick uart model,
// and a monitor that checks every ack against expected (requester, byte) pairs.
module tb_zrb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned BM = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   last = '0;
  logic [8*NR-1:0] data_in = '0;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   grant;
  logic            uart_clk_en = 1'b1;
  logic            uart_busy = 1'b0;
  logic            uart_write;
  logic [7:0]      uart_data;
  logic            active;

  zrb_uart_tx_arbiter #(.NUM_REQ(NR), .BURST_MAX(BM)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .last(last), .data_in(data_in),
    .ack(ack), .grant(grant), .uart_clk_en(uart_clk_en), .uart_busy(uart_busy),
    .uart_write(uart_write), .uart_data(uart_data), .active(active)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  strm [NR][$];  // {last, byte} per requester
  logic [11:0] exp_q [$];     // {requester, byte} in expected accept order
  int          busy_len = 0;
  bit          hold_busy = 1'b0;
  bit          en_slow = 1'b0;
  int          cyc = 0;
  bit          acc_next = 1'b0;
  int          acc_owner = 0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, got, expv, $time);
    end
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = 0;
    for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active) && n < 600) begin
      step(1);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_idle"}, active, 0);
    check({name, "_grant0"}, grant, 0);
  endtask

  // Requesters and uart model: inputs change 1ns after the rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
      acc_next = 1'b0;
      busy_cnt = 0;
    end else if (acc_next) begin
      busy_cnt = busy_len;
      if (strm[acc_owner].size() > 0) void'(strm[acc_owner].pop_front());
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_busy   = hold_busy || (busy_cnt > 0);
    uart_clk_en = !en_slow || (cyc % 3 == 0);
    for (int i = 0; i < NR; i++) begin
      req[i]             = (strm[i].size() > 0);
      data_in[8*i +: 8]  = req[i] ? strm[i][0][7:0] : 8'h00;
      last[i]            = req[i] ? strm[i][0][8] : 1'b0;
    end
    acc_next  = reset_n && uart_write && uart_clk_en && !uart_busy;
    acc_owner = oh2idx(grant);
  end

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && (ack != '0)) begin
      check("ack_onehot", 32'($onehot(ack)), 1);
      check("ack_write", uart_write, 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack actual=req%0d/%h required=none", oh2idx(ack), uart_data);
      end else begin
        check("ack_byte", {4'(oh2idx(ack)), uart_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_write", uart_write, 0);
    check("rst_data", uart_data, 8'h00);
    check("rst_active", active, 0);
    reset_n = 1'b1;
    step(1);

    // Single two-byte packet with 10-tick busy after each load.
    busy_len = 10;
    strm[0].push_back({1'b0, 8'h41});
    strm[0].push_back({1'b1, 8'h42});
    exp_q.push_back({4'd0, 8'h41});
    exp_q.push_back({4'd0, 8'h42});
    step(2);
    check("t1_grant", grant, 4'b0001);
    check("t1_active", active, 1);
    check("t1_nowrite", uart_write, 0);
    step(1);
    check("t1_write", {uart_write, uart_data}, {1'b1, 8'h41});
    wait_idle("t1");

    // Round robin from reset: 0,2,3,0.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    busy_len = 2;
    strm[0].push_back({1'b1, 8'h10});
    strm[0].push_back({1'b1, 8'h11});
    strm[2].push_back({1'b1, 8'h20});
    strm[3].push_back({1'b1, 8'h30});
    exp_q.push_back({4'd0, 8'h10});
    exp_q.push_back({4'd2, 8'h20});
    exp_q.push_back({4'd3, 8'h30});
    exp_q.push_back({4'd0, 8'h11});
    wait_idle("t2");

    // Burst cap of 4: req 1 streams 10 bytes with no last, req 2 interleaves.
    busy_len = 1;
    for (int i = 0; i < 10; i++) strm[1].push_back({1'b0, 8'(8'h60 + i)});
    strm[2].push_back({1'b0, 8'h70});
    strm[2].push_back({1'b1, 8'h71});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'd1, 8'(8'h60 + i)});
    exp_q.push_back({4'd2, 8'h70});
    exp_q.push_back({4'd2, 8'h71});
    for (int i = 4; i < 10; i++) exp_q.push_back({4'd1, 8'(8'h60 + i)});
    wait_idle("t3");

    // Owner 3 drops its request before LOAD samples it.
    busy_len = 0;
    strm[3].push_back({1'b1, 8'h33});
    step(1);
    strm[3].delete();
    step(1);
    check("t4_load_grant", grant, 4'b1000);
    check("t4_load_nowrite", uart_write, 0);
    step(1);
    check("t4_rel_grant", grant, 4'b1000);
    check("t4_rel_active", active, 1);
    check("t4_rel_nowrite", uart_write, 0);
    step(1);
    check("t4_idle_grant", grant, 0);
    check("t4_idle_active", active, 0);
    strm[0].push_back({1'b1, 8'h40});
    strm[3].push_back({1'b1, 8'h43});
    exp_q.push_back({4'd0, 8'h40});
    exp_q.push_back({4'd3, 8'h43});
    wait_idle("t4");

    // Write held for 50 cycles under busy, then released on a slow tick.
    hold_busy = 1'b1;
    strm[2].push_back({1'b1, 8'h5A});
    exp_q.push_back({4'd2, 8'h5A});
    for (int n = 0; n < 10 && !uart_write; n++) step(1);
    check("t5_write_seen", uart_write, 1);
    for (int n = 0; n < 50; n++) begin
      check("t5_hold", {uart_write, uart_data, ack}, {1'b1, 8'h5A, 4'b0000});
      step(1);
    end
    en_slow   = 1'b1;
    hold_busy = 1'b0;
    wait_idle("t5");
    en_slow = 1'b0;

    // Asynchronous reset while a byte is waiting in SEND.
    hold_busy = 1'b1;
    strm[1].push_back({1'b0, 8'h91});
    strm[1].push_back({1'b1, 8'h92});
    for (int n = 0; n < 10 && !uart_write; n++) step(1);
    check("t6_write_seen", uart_write, 1);
    reset_n = 1'b0;
    strm[1].delete();
    #1;
    check("t6_write", uart_write, 0);
    check("t6_grant", grant, 0);
    check("t6_ack", ack, 0);
    check("t6_active", active, 0);
    check("t6_data", uart_data, 8'h00);
    step(2);
    hold_busy = 1'b0;
    reset_n   = 1'b1;
    step(1);
    strm[3].push_back({1'b1, 8'hA3});
    strm[0].push_back({1'b1, 8'hA0});
    exp_q.push_back({4'd0, 8'hA0});
    exp_q.push_back({4'd3, 8'hA3});
    wait_idle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
